// File: rtl/muldiv_unit_if.sv
// Issue-side and CDB-side signals of the RV32M mul/div execute unit.
// The master drives issue and cdb_ready; the slave is the execute unit.
interface muldiv_unit_if #(
  parameter int ROB_IDX_WIDTH = 5
);
  logic                     flush;
  logic                     issue_valid;
  logic [2:0]               multop;
  logic [31:0]              rs1_data;
  logic [31:0]              rs2_data;
  logic [4:0]               rd_addr;
  logic [ROB_IDX_WIDTH-1:0] rd_rob_idx;
  logic                     available;
  logic                     cdb_ready;
  logic                     mul_valid;
  logic [31:0]              mul_data;
  logic [4:0]               mul_rd_addr;
  logic [ROB_IDX_WIDTH-1:0] mul_rob_idx;

  modport master (
    output flush, issue_valid, multop, rs1_data, rs2_data, rd_addr, rd_rob_idx, cdb_ready,
    input  available, mul_valid, mul_data, mul_rd_addr, mul_rob_idx
  );

  modport slave (
    input  flush, issue_valid, multop, rs1_data, rs2_data, rd_addr, rd_rob_idx, cdb_ready,
    output available, mul_valid, mul_data, mul_rd_addr, mul_rob_idx
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M execute unit: one op in flight, result presented on the CDB
// mul slot with valid/ready handoff. Restoring divider retires one bit per cycle.
module muldiv_unit #(
  parameter int MUL_CYCLES    = 3,
  parameter int ROB_IDX_WIDTH = 5
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(MUL_CYCLES + 33);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e                   state_q, state_d;
  logic [31:0]              a_q, a_d;
  logic [31:0]              b_q, b_d;
  logic [31:0]              rem_q, rem_d;
  logic [2:0]               op_q, op_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     qneg_q, qneg_d;
  logic                     rneg_q, rneg_d;
  logic [4:0]               rd_q, rd_d;
  logic [ROB_IDX_WIDTH-1:0] rob_q, rob_d;
  logic [31:0]              data_q, data_d;
  logic [4:0]               mrd_q, mrd_d;
  logic [ROB_IDX_WIDTH-1:0] mrob_q, mrob_d;

  logic                     accept;
  logic                     in_signed;
  logic                     in_divz;
  logic                     in_ovf;
  logic [32:0]              div_tmp;
  logic [32:0]              div_sub;
  logic                     div_ge;
  logic [31:0]              div_rem_nx;
  logic [31:0]              div_quo_nx;

  // 66-bit product of the sign/zero-extended operands; MUL keeps the low word.
  function automatic logic [31:0] mul_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op);
    logic        a_sgn;
    logic        b_sgn;
    logic [65:0] a_ext;
    logic [65:0] b_ext;
    logic [65:0] prod;
    a_sgn = (op != 3'd3) && a[31];
    b_sgn = ((op == 3'd0) || (op == 3'd1)) && b[31];
    a_ext = {{34{a_sgn}}, a};
    b_ext = {{34{b_sgn}}, b};
    prod  = a_ext * b_ext;
    return (op == 3'd0) ? prod[31:0] : prod[63:32];
  endfunction

  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (32'd0 - x) : x;
  endfunction

  // Restore signs: quotient negative when operand signs differ, remainder follows dividend.
  function automatic logic [31:0] div_result(input logic [31:0] quo, input logic [31:0] rem,
                                             input logic qneg, input logic rneg,
                                             input logic is_rem);
    logic [31:0] q;
    logic [31:0] r;
    q = qneg ? (32'd0 - quo) : quo;
    r = rneg ? (32'd0 - rem) : rem;
    return is_rem ? r : q;
  endfunction

  function automatic logic [31:0] div_special(input logic [31:0] a, input logic is_rem,
                                              input logic divz);
    if (divz) return is_rem ? a : 32'hFFFF_FFFF;
    return is_rem ? 32'h0 : 32'h8000_0000;
  endfunction

  assign accept    = (state_q == S_IDLE) && bus.issue_valid && !bus.flush;
  assign in_signed = !bus.multop[0];
  assign in_divz   = (bus.rs2_data == 32'h0);
  assign in_ovf    = in_signed && (bus.rs1_data == 32'h8000_0000) &&
                     (bus.rs2_data == 32'hFFFF_FFFF);

  assign div_tmp    = {rem_q, a_q[31]};
  assign div_ge     = (div_tmp >= {1'b0, b_q});
  assign div_sub    = div_tmp - {1'b0, b_q};
  assign div_rem_nx = div_ge ? div_sub[31:0] : div_tmp[31:0];
  assign div_quo_nx = {a_q[30:0], div_ge};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    rd_d    = rd_q;
    rob_d   = rob_q;
    data_d  = data_q;
    mrd_d   = mrd_q;
    mrob_d  = mrob_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = bus.multop;
          rd_d  = bus.rd_addr;
          rob_d = bus.rd_rob_idx;
          if (!bus.multop[2]) begin
            a_d = bus.rs1_data;
            b_d = bus.rs2_data;
            if (MUL_CYCLES == 1) begin
              state_d = S_DONE;
              data_d  = mul_result(bus.rs1_data, bus.rs2_data, bus.multop);
              mrd_d   = bus.rd_addr;
              mrob_d  = bus.rd_rob_idx;
            end else begin
              state_d = S_MUL;
              cnt_d   = CNT_W'(MUL_CYCLES - 2);
            end
          end else if (in_divz || in_ovf) begin
            state_d = S_DONE;
            data_d  = div_special(bus.rs1_data, bus.multop[1], in_divz);
            mrd_d   = bus.rd_addr;
            mrob_d  = bus.rd_rob_idx;
          end else begin
            state_d = S_DIV;
            a_d     = magnitude(bus.rs1_data, in_signed);
            b_d     = magnitude(bus.rs2_data, in_signed);
            rem_d   = 32'h0;
            cnt_d   = '0;
            qneg_d  = in_signed && (bus.rs1_data[31] ^ bus.rs2_data[31]);
            rneg_d  = in_signed && bus.rs1_data[31];
          end
        end
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          data_d  = mul_result(a_q, b_q, op_q);
          mrd_d   = rd_q;
          mrob_d  = rob_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV: begin
        a_d   = div_quo_nx;
        rem_d = div_rem_nx;
        if (cnt_q == CNT_W'(31)) begin
          state_d = S_DONE;
          data_d  = div_result(div_quo_nx, div_rem_nx, qneg_q, rneg_q, op_q[1]);
          mrd_d   = rd_q;
          mrob_d  = rob_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (bus.cdb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A killed op must not disturb the visible result registers.
    if (bus.flush) begin
      state_d = S_IDLE;
      data_d  = data_q;
      mrd_d   = mrd_q;
      mrob_d  = mrob_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      rd_q    <= '0;
      rob_q   <= '0;
      data_q  <= '0;
      mrd_q   <= '0;
      mrob_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      rd_q    <= rd_d;
      rob_q   <= rob_d;
      data_q  <= data_d;
      mrd_q   <= mrd_d;
      mrob_q  <= mrob_d;
    end
  end

  assign bus.available   = (state_q == S_IDLE);
  assign bus.mul_valid   = (state_q == S_DONE);
  assign bus.mul_data    = data_q;
  assign bus.mul_rd_addr = mrd_q;
  assign bus.mul_rob_idx = mrob_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M cases plus randomized ops checked
// against an arithmetic reference model, with backpressure and flush scenarios.
module tb_muldiv_unit;
  localparam int MUL_CYCLES = 3;
  localparam int ROB_W      = 5;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  muldiv_unit_if #(.ROB_IDX_WIDTH(ROB_W)) bus ();

  muldiv_unit #(.MUL_CYCLES(MUL_CYCLES), .ROB_IDX_WIDTH(ROB_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    longint      p;
    logic [63:0] up;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'h0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (!op[2]) return MUL_CYCLES;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [ROB_W-1:0] rob, input int delay);
    logic [31:0] exp;
    int          lat;
    exp = ref_res(op, a, b);
    @(negedge clk);
    chk("avail_pre", 32'(bus.available), 32'd1);
    bus.issue_valid = 1'b1;
    bus.multop      = op;
    bus.rs1_data    = a;
    bus.rs2_data    = b;
    bus.rd_addr     = rd;
    bus.rd_rob_idx  = rob;
    bus.cdb_ready   = (delay == 0);
    @(negedge clk);
    bus.issue_valid = 1'b0;
    lat = 1;
    while (!bus.mul_valid && lat < 100) begin
      chk("avail_busy", 32'(bus.available), 32'd0);
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(ref_lat(op, a, b)));
    chk("data", bus.mul_data, exp);
    chk("rd", 32'(bus.mul_rd_addr), 32'(rd));
    chk("rob", 32'(bus.mul_rob_idx), 32'(rob));
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.mul_valid), 32'd1);
      chk("hold_data", bus.mul_data, exp);
      chk("hold_rob", 32'(bus.mul_rob_idx), 32'(rob));
    end
    bus.cdb_ready = 1'b1;
    @(negedge clk);
    bus.cdb_ready = 1'b0;
    chk("post_valid", 32'(bus.mul_valid), 32'd0);
    chk("post_avail", 32'(bus.available), 32'd1);
    chk("post_data", bus.mul_data, exp);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst              = 1'b1;
    bus.flush        = 1'b0;
    bus.issue_valid  = 1'b0;
    bus.multop       = 3'd0;
    bus.rs1_data     = 32'h0;
    bus.rs2_data     = 32'h0;
    bus.rd_addr      = 5'd0;
    bus.rd_rob_idx   = '0;
    bus.cdb_ready    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_avail", 32'(bus.available), 32'd1);
    chk("rst_valid", 32'(bus.mul_valid), 32'd0);
    chk("rst_data", bus.mul_data, 32'h0);
    chk("rst_rd", 32'(bus.mul_rd_addr), 32'd0);
    chk("rst_rob", 32'(bus.mul_rob_idx), 32'd0);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 5'd9, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 5'd1, 0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 5'd2, 1);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 5'd3, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, 5'd17, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, 5'd18, 0);
    run_op(3'd5, 32'd5, 32'd0, 5'd12, 5'd19, 0);
    run_op(3'd7, 32'd5, 32'd0, 5'd13, 5'd20, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 5'd21, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 5'd22, 2);
    run_op(3'd5, 32'hFFFF_FFF9, 32'd2, 5'd16, 5'd23, 0);
    run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, 5'd30, 4);

    // Flush beats a coincident issue.
    @(negedge clk);
    bus.issue_valid = 1'b1;
    bus.flush       = 1'b1;
    bus.multop      = 3'd0;
    bus.rs1_data    = 32'd3;
    bus.rs2_data    = 32'd3;
    @(negedge clk);
    bus.issue_valid = 1'b0;
    bus.flush       = 1'b0;
    chk("flush_issue_avail", 32'(bus.available), 32'd1);
    chk("flush_issue_valid", 32'(bus.mul_valid), 32'd0);

    // Flush a divide in flight at T+10.
    bus.issue_valid = 1'b1;
    bus.multop      = 3'd4;
    bus.rs1_data    = 32'd1000;
    bus.rs2_data    = 32'd7;
    bus.rd_addr     = 5'd8;
    bus.rd_rob_idx  = 5'd8;
    bus.cdb_ready   = 1'b1;
    @(negedge clk);
    bus.issue_valid = 1'b0;
    for (int k = 1; k < 10; k++) begin
      chk("flush_pre_valid", 32'(bus.mul_valid), 32'd0);
      @(negedge clk);
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_avail", 32'(bus.available), 32'd1);
    for (int k = 0; k < 30; k++) begin
      chk("flush_no_valid", 32'(bus.mul_valid), 32'd0);
      @(negedge clk);
    end
    chk("flush_data_kept", bus.mul_data, ref_res(3'd0, 32'h1234_5678, 32'h9ABC_DEF0));
    bus.cdb_ready = 1'b0;
    run_op(3'd4, 32'd1000, 32'd7, 5'd9, 5'd9, 1);

    for (int n = 0; n < 40; n++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
